// File: rtl/seq_scan_arbiter_if.sv
// Bus between the word producers / serial 1101 detector and the
// seq_scan_arbiter. The arbiter connects through the slave modport and
// the producer/detector side connects through the master modport.
interface seq_scan_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [CNTW-1:0]       hit_count;
    logic                  det_x;
    logic                  det_rst_n;
    logic                  det_y;

    modport slave (
        input  req, req_data, det_y,
        output gnt, busy, done, done_id, hit_count, det_x, det_rst_n
    );

    modport master (
        output req, req_data, det_y,
        input  gnt, busy, done, done_id, hit_count, det_x, det_rst_n
    );
endinterface

// File: rtl/seq_scan_arbiter.sv
// Round-robin sharing of one bit-serial 1101 detector among NREQ word
// producers. A granted word is shifted MSB first into a freshly cleared
// detector, hits are counted (saturating) and returned with the requester
// id. MOORE selects which cycles of det_y are counted: a registered
// detector reports the match one cycle late, so its count window is moved
// one cycle later (skip SHIFT k=0, include DRAIN).
module seq_scan_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int CNTW  = 4,
    parameter bit MOORE = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    seq_scan_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int KW  = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0]   hit_q, hit_d;
    logic [IDW-1:0]    done_id_q, done_id_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              det_x_q, det_x_d;
    logic              det_rst_n_q, det_rst_n_d;

    logic [WIDTH-1:0]  words [NREQ];
    logic              pick_valid;
    logic [IDW-1:0]    pick_id;
    logic [CNTW-1:0]   cnt_add;

    // Unpack the flat request bus into one word per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
        assign words[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end

    // Round-robin pick: scan from farthest to nearest after ptr so the
    // nearest requester at or after ptr+1 overwrites the others.
    always_comb begin
        logic [IDW-1:0] idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int o = NREQ; o >= 1; o--) begin
            idx = IDW'((int'(ptr_q) + o) % NREQ);
            if (bus.req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

    // Saturating hit increment driven by the detector output.
    always_comb begin
        cnt_add = cnt_q;
        if (bus.det_y && (cnt_q != {CNTW{1'b1}})) begin
            cnt_add = cnt_q + CNTW'(1);
        end
    end

    // Next-state and next-output logic of the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        armed_d     = 1'b1;
        ptr_d       = ptr_q;
        id_d        = id_q;
        word_d      = word_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        hit_d       = hit_q;
        done_id_d   = done_id_q;
        gnt_d       = '0;
        det_x_d     = 1'b0;
        det_rst_n_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                // armed_q blocks acceptance on the first edge after reset.
                if (armed_q && pick_valid) begin
                    state_d     = S_CLR;
                    ptr_d       = pick_id;
                    id_d        = pick_id;
                    word_d      = words[pick_id];
                    gnt_d       = NREQ'(1) << pick_id;
                    det_rst_n_d = 1'b0;
                end
            end
            S_CLR: begin
                state_d = S_SHIFT;
                k_d     = '0;
                cnt_d   = '0;
                det_x_d = word_q[WIDTH-1];
                word_d  = {word_q[WIDTH-2:0], 1'b0};
            end
            S_SHIFT: begin
                if (!MOORE || (k_q != '0)) begin
                    cnt_d = cnt_add;
                end
                if (k_q == KW'(WIDTH-1)) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d     = k_q + KW'(1);
                    det_x_d = word_q[WIDTH-1];
                    word_d  = {word_q[WIDTH-2:0], 1'b0};
                end
            end
            S_DRAIN: begin
                // A registered detector reports the final-bit match here.
                state_d   = S_DONE;
                hit_d     = MOORE ? cnt_add : cnt_q;
                cnt_d     = hit_d;
                done_id_d = id_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset holds the detector in reset too.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            ptr_q       <= IDW'(NREQ-1);
            id_q        <= '0;
            word_q      <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            hit_q       <= '0;
            done_id_q   <= '0;
            gnt_q       <= '0;
            det_x_q     <= 1'b0;
            det_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            word_q      <= word_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            done_id_q   <= done_id_d;
            gnt_q       <= gnt_d;
            det_x_q     <= det_x_d;
            det_rst_n_q <= det_rst_n_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.done_id   = done_id_q;
    assign bus.hit_count = hit_q;
    assign bus.det_x     = det_x_q;
    assign bus.det_rst_n = det_rst_n_q;
endmodule
